frame_reg_writer: RTL and testbench

- Bus-side writer for the sprite/score display peripheral: it drives the peripheral's chipselect/write/address/writedata register interface from hardware game state.
- Once per frame, on the start of vertical sync, it snapshots sprite positions and the binary score.
- It converts the score to 3 BCD digits with a sequential double-dabble, then issues one write per display register.
- It sits between the game-logic core and the display peripheral. Its vsync input is the peripheral's VGA_VS output.

---
 rtl/frame_reg_writer.sv | 202 ++++++++++++++++++++
 tb/tb_frame_reg_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reg_writer.sv
// Per-frame register writer for the sprite/score display peripheral.
// Define DIRTY_SKIP_EN to skip registers whose value did not change.
module frame_reg_writer #(
  parameter int NUM_POS_REGS    = 12,
  parameter int SCORE_BASE_ADDR = 12,
  parameter int WRITE_GAP       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      vga_vs,
  input  logic [8*NUM_POS_REGS-1:0] obj_pos,
  input  logic [9:0]                score,
  output logic                      chipselect,
  output logic                      write,
  output logic [8:0]                address,
  output logic [31:0]               writedata,
  output logic                      busy,
  output logic [7:0]                overrun_count
);

  localparam int NREG = NUM_POS_REGS + 3;
  localparam int IW   = $clog2(NREG + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                      vs_q;
  logic [8*NUM_POS_REGS-1:0] shadow_q;
  logic [9:0]                bin_q;
  logic [11:0]               bcd_q;
  logic [3:0]                cnt_q;
  logic [IW-1:0]             idx_q;
  logic [3:0]                gap_q;

  logic                      trig;
  logic                      accept;
  logic                      finishing;
  logic                      overrun;
  logic                      strobe;
  logic                      pick_found;
  logic                      more;
  logic [IW-1:0]             pick_idx;
  logic [NREG-1:0]           dirty;
  logic [7:0]                val [2**IW];

  logic                      cs_d;
  logic                      busy_d;
  logic [8:0]                addr_d;
  logic [31:0]               wd_d;

  function automatic logic [21:0] dd_step(
    input logic [11:0] b,
    input logic [9:0]  x
  );
    logic [11:0] a;
    for (int n = 0; n < 3; n++) begin
      if (b[4*n+:4] >= 4'd5) a[4*n+:4] = b[4*n+:4] + 4'd3;
      else                   a[4*n+:4] = b[4*n+:4];
    end
    return {a, x} << 1;
  endfunction

  function automatic logic [8:0] reg_addr(input logic [IW-1:0] k);
    if (int'(k) < NUM_POS_REGS) return 9'(k);
    return 9'(SCORE_BASE_ADDR + int'(k) - NUM_POS_REGS);
  endfunction

  assign trig = vs_q & ~vga_vs;

  always_comb begin : val_c
    for (int i = 0; i < 2**IW; i++) val[i] = '0;
    for (int k = 0; k < NUM_POS_REGS; k++) val[k] = shadow_q[8*k+:8];
    val[NUM_POS_REGS]   = {4'b0, bcd_q[11:8]};
    val[NUM_POS_REGS+1] = {4'b0, bcd_q[7:4]};
    val[NUM_POS_REGS+2] = {4'b0, bcd_q[3:0]};
  end

`ifdef DIRTY_SKIP_EN
  logic [7:0] last_q [2**IW];
  logic       all_valid_q;

  always_comb begin : dirty_c
    dirty = '0;
    for (int k = 0; k < NREG; k++)
      dirty[k] = !all_valid_q || (last_q[k] != val[k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      all_valid_q <= 1'b0;
      for (int k = 0; k < 2**IW; k++) last_q[k] <= '0;
    end else if (strobe) begin
      last_q[pick_idx] <= val[pick_idx];
      if (!more) all_valid_q <= 1'b1;
    end
  end
`else
  assign dirty = '1;
`endif

  // Next register to write at or after idx_q, and whether any follows it.
  always_comb begin : pick_c
    pick_found = 1'b0;
    pick_idx   = '0;
    more       = 1'b0;
    for (int k = 0; k < NREG; k++)
      if (dirty[k] && k >= int'(idx_q) && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = IW'(k);
      end
    for (int k = 0; k < NREG; k++)
      if (dirty[k] && pick_found && k > int'(pick_idx)) more = 1'b1;
  end

  assign strobe    = (state_q == WRITE) && (gap_q == 4'd0) && pick_found;
  assign finishing = (state_q == DONE) ||
                     ((state_q == WRITE) && (gap_q == 4'd0) && !pick_found);
  assign accept    = trig && enable && ((state_q == IDLE) || finishing);
  assign overrun   = trig && (state_q != IDLE) && !finishing;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_c
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (cnt_q == 4'd9) state_d = WRITE;
      WRITE: begin
        if (finishing)          state_d = accept ? CONVERT : IDLE;
        else if (strobe && !more) state_d = DONE;
      end
      DONE:    state_d = accept ? CONVERT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : out_c
    cs_d   = strobe;
    addr_d = address;
    wd_d   = writedata;
    busy_d = 1'b1;
    if (strobe) begin
      addr_d = reg_addr(pick_idx);
      wd_d   = {24'b0, val[pick_idx]};
    end
    if ((state_q == IDLE) || finishing) busy_d = accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q          <= 1'b1;
      shadow_q      <= '0;
      bin_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      idx_q         <= '0;
      gap_q         <= '0;
      chipselect    <= 1'b0;
      write         <= 1'b0;
      address       <= '0;
      writedata     <= '0;
      busy          <= 1'b0;
      overrun_count <= '0;
    end else begin
      vs_q       <= vga_vs;
      chipselect <= cs_d;
      write      <= cs_d;
      address    <= addr_d;
      writedata  <= wd_d;
      busy       <= busy_d;
      if (overrun && overrun_count != 8'hff)
        overrun_count <= overrun_count + 8'd1;
      if (accept) begin
        shadow_q <= obj_pos;
        bin_q    <= (score > 10'd999) ? 10'd999 : score;
        bcd_q    <= '0;
        cnt_q    <= '0;
        idx_q    <= '0;
        gap_q    <= '0;
      end else if (state_q == CONVERT) begin
        {bcd_q, bin_q} <= dd_step(bcd_q, bin_q);
        cnt_q          <= cnt_q + 4'd1;
      end else if (strobe) begin
        idx_q <= pick_idx + IW'(1);
        gap_q <= 4'(WRITE_GAP);
      end else if ((state_q == WRITE) && (gap_q != 4'd0)) begin
        gap_q <= gap_q - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_reg_writer.sv
// Directed bench for frame_reg_writer: default build and WRITE_GAP=2 copy.
module tb_frame_reg_writer;

  localparam int NP = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic            vga_vs = 1'b1;
  logic [8*NP-1:0] obj_pos = '0;
  logic [9:0]      score = '0;

  logic            cs_a, wr_a, busy_a;
  logic [8:0]      addr_a;
  logic [31:0]     wd_a;
  logic [7:0]      ovr_a;
  logic            cs_b, wr_b, busy_b;
  logic [8:0]      addr_b;
  logic [31:0]     wd_b;
  logic [7:0]      ovr_b;

  int checks = 0;
  int errors = 0;

  int          na, nb, a_drop, b_drop, hold_bad, cs_bad;
  logic [8:0]  a_addr [32];
  logic [8:0]  b_addr [32];
  logic [31:0] a_data [32];
  logic [31:0] b_data [32];
  int          a_edge [32];
  int          b_edge [32];

  frame_reg_writer u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .vga_vs(vga_vs),
    .obj_pos(obj_pos), .score(score),
    .chipselect(cs_a), .write(wr_a), .address(addr_a),
    .writedata(wd_a), .busy(busy_a), .overrun_count(ovr_a)
  );

  frame_reg_writer #(.WRITE_GAP(2)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .vga_vs(vga_vs),
    .obj_pos(obj_pos), .score(score),
    .chipselect(cs_b), .write(wr_b), .address(addr_b),
    .writedata(wd_b), .busy(busy_b), .overrun_count(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_pos();
    for (int k = 0; k < NP; k++) obj_pos[8*k+:8] = 8'(k + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pre_frame();
`ifdef DIRTY_SKIP_EN
    do_reset();
`endif
  endtask

  // Trigger at edge 0, then sample #1 after each edge and log strobes.
  task automatic run_frame(input int ovr_edge, input bit perturb);
    na = 0; nb = 0; a_drop = -1; b_drop = -1;
    hold_bad = 0; cs_bad = 0;
    @(negedge clk);
    vga_vs = 1'b0;
    @(posedge clk);
    #1;
    vga_vs = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk);
      #1;
      if (cs_a !== wr_a || cs_b !== wr_b) cs_bad++;
      if (cs_a === 1'b1 && na < 32) begin
        a_addr[na] = addr_a; a_data[na] = wd_a; a_edge[na] = e; na++;
      end
      if (cs_b === 1'b1 && nb < 32) begin
        b_addr[nb] = addr_b; b_data[nb] = wd_b; b_edge[nb] = e; nb++;
      end else if (busy_b === 1'b1 && nb > 0) begin
        if (addr_b !== b_addr[nb-1] || wd_b !== b_data[nb-1]) hold_bad++;
      end
      if (a_drop < 0 && busy_a === 1'b0) a_drop = e;
      if (b_drop < 0 && busy_b === 1'b0) b_drop = e;
      vga_vs = (e == ovr_edge - 1) ? 1'b0 : 1'b1;
      if (perturb && e == 1) begin
        obj_pos = ~obj_pos;
        score   = 10'd7;
        enable  = 1'b0;
      end
      if (a_drop >= 0 && b_drop >= 0) break;
    end
  endtask

  task automatic verify_frame(input string t, input logic [3:0] h,
                              input logic [3:0] tn, input logic [3:0] o);
    logic [31:0] exp;
    chk({t, "_na"}, 32'(na), 32'd15);
    chk({t, "_nb"}, 32'(nb), 32'd15);
    for (int k = 0; k < 15; k++) begin
      if (k < NP)       exp = 32'(k + 1);
      else if (k == NP) exp = {28'b0, h};
      else if (k == 13) exp = {28'b0, tn};
      else              exp = {28'b0, o};
      if (k < na) begin
        chk($sformatf("%s_addr%0d", t, k), 32'(a_addr[k]), 32'(k));
        chk($sformatf("%s_data%0d", t, k), a_data[k], exp);
        chk($sformatf("%s_edge%0d", t, k), 32'(a_edge[k]), 32'(11 + k));
      end
      if (k < nb && k >= NP)
        chk($sformatf("%s_bdata%0d", t, k), b_data[k], exp);
    end
    chk({t, "_adrop"}, 32'(a_drop), 32'd26);
    if (nb > 0) begin
      chk({t, "_bfirst"}, 32'(b_edge[0]), 32'd11);
      chk({t, "_blast"}, 32'(b_edge[nb-1]), 32'd53);
      chk({t, "_baddr"}, 32'(b_addr[nb-1]), 32'd14);
    end
    chk({t, "_bdrop"}, 32'(b_drop), 32'd54);
    chk({t, "_hold"}, 32'(hold_bad), 32'd0);
    chk({t, "_cswr"}, 32'(cs_bad), 32'd0);
  endtask

  initial begin
    int cnt;
    set_pos();
    score = 10'd345;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_wr", 32'(wr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_data", wd_a, 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_frame(0, 1'b0);
    verify_frame("s345", 4'd3, 4'd4, 4'd5);

    enable = 1'b0;
    @(negedge clk);
    vga_vs = 1'b0;
    @(negedge clk);
    vga_vs = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (busy_a !== 1'b0 || cs_a !== 1'b0) cnt++;
    end
    chk("en0_idle", 32'(cnt), 32'd0);
    chk("en0_ovr", 32'(ovr_a), 32'd0);
    enable = 1'b1;

    pre_frame();
    score = 10'd1023;
    run_frame(0, 1'b0);
    verify_frame("s1023", 4'd9, 4'd9, 4'd9);

    pre_frame();
    score = 10'd0;
    run_frame(0, 1'b0);
    verify_frame("s0", 4'd0, 4'd0, 4'd0);

    pre_frame();
    score = 10'd999;
    run_frame(0, 1'b1);
    verify_frame("s999", 4'd9, 4'd9, 4'd9);
    set_pos();
    enable = 1'b1;

    pre_frame();
    score = 10'd345;
    run_frame(5, 1'b0);
    verify_frame("ovr", 4'd3, 4'd4, 4'd5);
    chk("ovr_a1", 32'(ovr_a), 32'd1);
    chk("ovr_b1", 32'(ovr_b), 32'd1);

    repeat (700) begin
      @(negedge clk);
      vga_vs = ~vga_vs;
    end
    @(negedge clk);
    vga_vs = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("sat_a", 32'(ovr_a), 32'd255);
    chk("sat_b", 32'(ovr_b), 32'd255);

    @(negedge clk);
    vga_vs = 1'b0;
    @(posedge clk);
    #1;
    vga_vs = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_cs_pre", 32'(cs_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_cs", 32'(cs_a), 32'd0);
    chk("mid_wr", 32'(wr_a), 32'd0);
    chk("mid_busy", 32'(busy_a), 32'd0);
    chk("mid_addr", 32'(addr_a), 32'd0);
    chk("mid_busyb", 32'(busy_b), 32'd0);
    chk("mid_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(0, 1'b0);
    verify_frame("post", 4'd3, 4'd4, 4'd5);

`ifdef DIRTY_SKIP_EN
    do_reset();
    run_frame(0, 1'b0);
    chk("dirty_f1", 32'(na), 32'd15);
    obj_pos[7:0] = 8'h55;
    run_frame(0, 1'b0);
    chk("dirty_f2n", 32'(na), 32'd1);
    chk("dirty_f2a", 32'(a_addr[0]), 32'd0);
    chk("dirty_f2d", a_data[0], 32'h55);
    chk("dirty_f2e", 32'(a_edge[0]), 32'd11);
    chk("dirty_f2drop", 32'(a_drop), 32'd12);
    run_frame(0, 1'b0);
    chk("dirty_f3n", 32'(na), 32'd0);
    chk("dirty_f3drop", 32'(a_drop), 32'd11);
    chk("dirty_f3bdrop", 32'(b_drop), 32'd11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
